// File: rtl/btb_predictor.sv
// Branch-target predictor: 16-entry BTB with 2-bit direction counters and a
// two-stage registered update path. Define BTB_STATS_EN to add update/mispredict counters.

module btb_array #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [3:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [3:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b
);
  logic [WIDTH-1:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

module btb_predictor #(
  parameter logic [1:0] ALLOC_CTR = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] fetch_pc,
  output logic        predict_taken,
  output logic [15:0] predict_target,
  input  logic        update_valid,
  input  logic [15:0] update_pc,
  input  logic        update_taken,
  input  logic [15:0] update_target,
  input  logic        update_pred_taken,
  input  logic        flush_all
`ifdef BTB_STATS_EN
  ,
  output logic [15:0] stat_updates,
  output logic [15:0] stat_mispredicts
`endif
);
  logic [15:0] valid;
  logic [1:0]  ctr [16];

  // U1: registered update inputs
  logic        u1_vld;
  logic [3:0]  u1_idx;
  logic [10:0] u1_tag;
  logic        u1_taken;
  logic [15:0] u1_target;
  logic        u1_pred_taken;

  // U2: record of the write just committed, used for same-index forwarding
  logic        u2_vld;
  logic [3:0]  u2_idx;
  logic [10:0] u2_tag;
  logic [1:0]  u2_ctr;

  logic [3:0]  f_idx;
  logic [10:0] f_tag;
  logic [10:0] tag_rd_f, tag_rd_u;
  logic [15:0] tgt_rd_f, tgt_rd_u;
  logic        f_hit;

  logic        fwd;
  logic        cur_hit;
  logic [1:0]  cur_ctr;
  logic [1:0]  new_ctr;
  logic        commit;
  logic        wr_ctr_en, wr_tag_en, wr_tgt_en;

  logic        unused_ok;
`ifdef BTB_STATS_EN
  assign unused_ok = update_pc[0] ^ tgt_rd_u[0];
`else
  assign unused_ok = update_pc[0] ^ tgt_rd_u[0] ^ u1_pred_taken;
`endif

  assign f_idx = fetch_pc[4:1];
  assign f_tag = fetch_pc[15:5];

  btb_array #(.WIDTH(11)) u_tag_array (
    .clk     (clk),
    .we      (wr_tag_en),
    .waddr   (u1_idx),
    .wdata   (u1_tag),
    .raddr_a (f_idx),
    .rdata_a (tag_rd_f),
    .raddr_b (u1_idx),
    .rdata_b (tag_rd_u)
  );

  btb_array #(.WIDTH(16)) u_target_array (
    .clk     (clk),
    .we      (wr_tgt_en),
    .waddr   (u1_idx),
    .wdata   (u1_target),
    .raddr_a (f_idx),
    .rdata_a (tgt_rd_f),
    .raddr_b (u1_idx),
    .rdata_b (tgt_rd_u)
  );

  always_comb begin
    f_hit          = valid[f_idx] && (tag_rd_f == f_tag);
    predict_taken  = f_hit && ctr[f_idx][1];
    predict_target = predict_taken ? tgt_rd_f : fetch_pc + 16'd2;
  end

  always_comb begin
    fwd     = u2_vld && (u2_idx == u1_idx);
    cur_hit = fwd ? (u2_tag == u1_tag) : (valid[u1_idx] && (tag_rd_u == u1_tag));
    cur_ctr = fwd ? u2_ctr : ctr[u1_idx];
    new_ctr = cur_ctr;
    if (cur_hit) begin
      if (u1_taken) new_ctr = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
      else          new_ctr = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
    end else if (u1_taken) begin
      new_ctr = ALLOC_CTR;
    end
    // Reset and flush both cancel the write that U1 would commit this edge.
    commit    = u1_vld && !reset && !flush_all;
    wr_ctr_en = commit && (cur_hit || u1_taken);
    wr_tag_en = commit && !cur_hit && u1_taken;
    wr_tgt_en = commit && u1_taken;
  end

  always_ff @(posedge clk) begin
    u1_idx        <= update_pc[4:1];
    u1_tag        <= update_pc[15:5];
    u1_taken      <= update_taken;
    u1_target     <= update_target;
    u1_pred_taken <= update_pred_taken;
    u2_idx        <= u1_idx;
    u2_tag        <= u1_tag;
    u2_ctr        <= new_ctr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= '0;
      u1_vld <= 1'b0;
      u2_vld <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) ctr[i] <= 2'b01;
    end else if (flush_all) begin
      valid  <= '0;
      u1_vld <= 1'b0;
      u2_vld <= 1'b0;
    end else begin
      u1_vld <= update_valid;
      u2_vld <= wr_ctr_en;
      if (wr_ctr_en) begin
        valid[u1_idx] <= 1'b1;
        ctr[u1_idx]   <= new_ctr;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (commit) begin
      if (stat_updates != 16'hFFFF) stat_updates <= stat_updates + 16'd1;
      if ((u1_pred_taken != u1_taken) && (stat_mispredicts != 16'hFFFF))
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed scenarios plus randomized
// traffic compared against a per-entry behavioural model.

module tb_btb_predictor;
  logic        clk;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        predict_taken;
  logic [15:0] predict_target;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_pred_taken;
  logic        flush_all;
`ifdef BTB_STATS_EN
  logic [15:0] stat_updates;
  logic [15:0] stat_mispredicts;
`endif

  int checks;
  int failures;

  btb_predictor #(.ALLOC_CTR(2'b10)) dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_pc          (fetch_pc),
    .predict_taken     (predict_taken),
    .predict_target    (predict_target),
    .update_valid      (update_valid),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_pred_taken (update_pred_taken),
    .flush_all         (flush_all)
`ifdef BTB_STATS_EN
    ,
    .stat_updates      (stat_updates),
    .stat_mispredicts  (stat_mispredicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: per-entry state plus one pending resolved branch that
  // becomes visible one edge after it was accepted.
  bit          m_valid [16];
  logic [10:0] m_tag   [16];
  logic [15:0] m_tgt   [16];
  logic [1:0]  m_ctr   [16];
  bit          p_vld;
  logic [15:0] p_pc, p_tgt;
  bit          p_taken, p_pred;
  int          m_upd, m_mis;

  task automatic model_apply(input logic [15:0] pc, input bit taken,
                             input logic [15:0] tgt, input bit pred);
    int idx;
    bit hit;
    idx = int'(pc[4:1]);
    hit = m_valid[idx] && (m_tag[idx] == pc[15:5]);
    if (hit) begin
      if (taken) begin
        if (m_ctr[idx] < 2'd3) m_ctr[idx] = m_ctr[idx] + 2'd1;
        m_tgt[idx] = tgt;
      end else if (m_ctr[idx] > 2'd0) begin
        m_ctr[idx] = m_ctr[idx] - 2'd1;
      end
    end else if (taken) begin
      m_valid[idx] = 1;
      m_tag[idx]   = pc[15:5];
      m_tgt[idx]   = tgt;
      m_ctr[idx]   = 2'b10;
    end
    if (m_upd < 65535) m_upd++;
    if (pred != taken && m_mis < 65535) m_mis++;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0;
        m_ctr[i]   = 2'b01;
      end
      p_vld = 0;
      m_upd = 0;
      m_mis = 0;
    end else if (flush_all) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      p_vld = 0;
    end else begin
      if (p_vld) model_apply(p_pc, p_taken, p_tgt, p_pred);
      p_vld   = update_valid;
      p_pc    = update_pc;
      p_taken = update_taken;
      p_tgt   = update_target;
      p_pred  = update_pred_taken;
    end
    #1;
  endtask

  function automatic void model_pred(input logic [15:0] pc, output bit tk,
                                     output logic [15:0] tg);
    int idx;
    idx = int'(pc[4:1]);
    tk  = m_valid[idx] && (m_tag[idx] == pc[15:5]) && m_ctr[idx][1];
    tg  = tk ? m_tgt[idx] : pc + 16'd2;
  endfunction

  task automatic do_update(input logic [15:0] pc, input bit taken,
                           input logic [15:0] tgt, input bit pred);
    update_valid      = 1'b1;
    update_pc         = pc;
    update_taken      = taken;
    update_target     = tgt;
    update_pred_taken = pred;
    step();
    update_valid      = 1'b0;
  endtask

  task automatic test_reset();
    bit          et;
    logic [15:0] eg;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    fetch_pc = 16'h3000;
    #1;
    model_pred(fetch_pc, et, eg);
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 16'h3002 || et || eg !== 16'h3002) begin
      $display("FAIL reset_lookup taken=%b target=%h required 0/3002", predict_taken, predict_target);
      failures++;
    end
    fetch_pc = 16'hFFFE;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 16'h0000) begin
      $display("FAIL wrap_lookup taken=%b target=%h required 0/0000", predict_taken, predict_target);
      failures++;
    end
  endtask

  task automatic test_basic();
    do_update(16'h3004, 1, 16'h3100, 0);
    fetch_pc = 16'h3004;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 16'h3006) begin
      $display("FAIL no_bypass taken=%b target=%h required 0/3006", predict_taken, predict_target);
      failures++;
    end
    step();
    checks++;
    if (predict_taken !== 1'b1 || predict_target !== 16'h3100) begin
      $display("FAIL alloc_visible taken=%b target=%h required 1/3100", predict_taken, predict_target);
      failures++;
    end
  endtask

  task automatic test_alias();
    fetch_pc = 16'h3024;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 16'h3026) begin
      $display("FAIL alias_miss taken=%b target=%h required 0/3026", predict_taken, predict_target);
      failures++;
    end
    do_update(16'h3024, 1, 16'h4000, 1);
    step();
    fetch_pc = 16'h3004;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 16'h3006) begin
      $display("FAIL alias_evict taken=%b target=%h required 0/3006", predict_taken, predict_target);
      failures++;
    end
    fetch_pc = 16'h3024;
    #1;
    checks++;
    if (predict_taken !== 1'b1 || predict_target !== 16'h4000) begin
      $display("FAIL alias_new taken=%b target=%h required 1/4000", predict_taken, predict_target);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_tg [3];
    bit          exp_tk [3];
    exp_tk = '{1'b0, 1'b1, 1'b1};
    exp_tg = '{16'h3006, 16'h3100, 16'h3100};
    do_update(16'h3004, 1, 16'h3100, 0);
    step();
    fetch_pc = 16'h3004;
    do_update(16'h3004, 0, 16'h0, 1);
    do_update(16'h3004, 0, 16'h0, 1);
    step();
    checks++;
    if (predict_taken !== exp_tk[0] || predict_target !== exp_tg[0]) begin
      $display("FAIL b2b_not_taken taken=%b target=%h required %b/%h", predict_taken, predict_target, exp_tk[0], exp_tg[0]);
      failures++;
    end
    do_update(16'h3004, 1, 16'h3100, 0);
    do_update(16'h3004, 1, 16'h3100, 0);
    do_update(16'h3004, 1, 16'h3100, 0);
    step();
    checks++;
    if (predict_taken !== exp_tk[1] || predict_target !== exp_tg[1]) begin
      $display("FAIL b2b_taken taken=%b target=%h required %b/%h", predict_taken, predict_target, exp_tk[1], exp_tg[1]);
      failures++;
    end
    // A single not-taken after saturation must still predict taken (11 -> 10).
    do_update(16'h3004, 0, 16'h0, 1);
    step();
    checks++;
    if (predict_taken !== exp_tk[2] || predict_target !== exp_tg[2]) begin
      $display("FAIL b2b_saturate taken=%b target=%h required %b/%h", predict_taken, predict_target, exp_tk[2], exp_tg[2]);
      failures++;
    end
  endtask

  task automatic test_flush();
    logic [15:0] pcs [3];
    pcs = '{16'h5000, 16'h3004, 16'h3024};
    flush_all = 1'b1;
    do_update(16'h5000, 1, 16'h5100, 1);
    flush_all = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      fetch_pc = pcs[i];
      #1;
      checks++;
      if (predict_taken !== 1'b0 || predict_target !== pcs[i] + 16'd2) begin
        $display("FAIL flush_miss pc=%h taken=%b target=%h required 0/%h", pcs[i], predict_taken, predict_target, pcs[i] + 16'd2);
        failures++;
      end
    end
    // Update in flight when the flush lands is cancelled too.
    do_update(16'h5000, 1, 16'h5100, 1);
    flush_all = 1'b1;
    step();
    flush_all = 1'b0;
    step();
    fetch_pc = 16'h5000;
    #1;
    checks++;
    if (predict_taken !== 1'b0 || predict_target !== 16'h5002) begin
      $display("FAIL flush_inflight taken=%b target=%h required 0/5002", predict_taken, predict_target);
      failures++;
    end
  endtask

  task automatic test_random();
    logic [10:0] tags [3];
    bit          et;
    logic [15:0] eg;
    tags = '{11'h180, 11'h181, 11'h2A0};
    for (int n = 0; n < 600; n++) begin
      reset             = ($urandom_range(0, 99) == 0);
      flush_all         = ($urandom_range(0, 39) == 0);
      update_valid      = ($urandom_range(0, 2) != 0);
      update_pc         = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
      update_taken      = 1'($urandom_range(0, 1));
      update_target     = 16'($urandom);
      update_pred_taken = 1'($urandom_range(0, 1));
      fetch_pc          = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
      #1;
      model_pred(fetch_pc, et, eg);
      checks++;
      if (predict_taken !== et || predict_target !== eg) begin
        $display("FAIL random_lookup n=%0d pc=%h taken=%b/%b target=%h/%h", n, fetch_pc, predict_taken, et, predict_target, eg);
        failures++;
      end
`ifdef BTB_STATS_EN
      checks++;
      if (stat_updates !== 16'(m_upd) || stat_mispredicts !== 16'(m_mis)) begin
        $display("FAIL random_stats n=%0d updates=%0d/%0d mispredicts=%0d/%0d", n, stat_updates, m_upd, stat_mispredicts, m_mis);
        failures++;
      end
`endif
      step();
    end
    reset = 1'b0;
    flush_all = 1'b0;
    update_valid = 1'b0;
  endtask

`ifdef BTB_STATS_EN
  task automatic test_stats();
    bit pred [5];
    bit tk   [5];
    pred = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tk   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) do_update(16'h6000 + 16'(i * 2), tk[i], 16'h7000, pred[i]);
    step();
    step();
    checks++;
    if (stat_updates !== 16'd5 || stat_mispredicts !== 16'd2) begin
      $display("FAIL stats_count updates=%0d mispredicts=%0d required 5/2", stat_updates, stat_mispredicts);
      failures++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (stat_updates !== 16'd0 || stat_mispredicts !== 16'd0) begin
      $display("FAIL stats_reset updates=%0d mispredicts=%0d required 0/0", stat_updates, stat_mispredicts);
      failures++;
    end
  endtask
`endif

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    flush_all         = 1'b0;
    fetch_pc          = '0;
    update_valid      = 1'b0;
    update_pc         = '0;
    update_taken      = 1'b0;
    update_target     = '0;
    update_pred_taken = 1'b0;
    p_vld             = 0;
    m_upd             = 0;
    m_mis             = 0;
    test_reset();
    test_basic();
    test_alias();
    test_back_to_back();
    test_flush();
    test_random();
`ifdef BTB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
